// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath controller (master) and the memory (slave).
// Latency: none, plain wires.
// Backpressure: the master may only present a request while busy is low; the slave ignores req otherwise.
interface mem_responder_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             ready;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word memory answering one request at a time; MEM_RESP_ALIGN_CHECK_EN adds a misalignment check.
// Latency: ready pulses LATENCY cycles after acceptance, then one IDLE cycle before the next accept.
// Backpressure: req is sampled only while busy=0; a req seen while busy is dropped, never queued.
module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2   // legal range 1..15, fits the 4-bit counter
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  mem_wr;
    logic [WIDTH-1:0]      mem [DEPTH];

    // Upper address bits wrap away, and the byte offset only matters with the align check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[WIDTH-1:DEPTH_LOG2+2], bus.addr[1:0]};

    // Next-state, capture and access decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        mem_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    idx_d   = bus.addr[DEPTH_LOG2+1:2];
                    wdata_d = bus.wdata;
                    mis_d   = ALIGN_CHECK && (bus.addr[1:0] != 2'b00);
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    // A misaligned access commits nothing and returns zero.
                    if (mis_q) begin
                        rdata_d = '0;
                    end else if (we_q) begin
                        mem_wr = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and capture registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Storage array, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ready = (state_q == S_RESP);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.rdata = rdata_q;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign bus.err   = (state_q == S_RESP) && mis_q;
`else
    assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of single accesses plus reset-abort, held-req and align sequences.
// Latency: checks ready arrives LATENCY cycles after acceptance via a scoreboard of expected cycles.
// Backpressure: drives req only when busy=0, except the held-req sequence which keeps req high.
module tb_mem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    int          ready_cycs[$];
    vec_t        vecs[9];
    exp_t        mon_e;
    logic [31:0] h_addr[3];
    logic [31:0] h_exp[3];
    logic [31:0] final_rdata;

    mem_responder_if #(.WIDTH(32)) bus();

    mem_responder #(
        .WIDTH(32),
        .DEPTH_LOG2(8),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Returns at a falling edge with busy low.
    task automatic wait_idle();
        for (int i = 0; i < 50 && bus.busy === 1'b1; i++) @(negedge clk);
        if (bus.busy !== 1'b0) timeout("wait_idle");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            timeout("wait_drain");
            sb.delete();
        end
    endtask

    task automatic expect_resp(input logic [31:0] rd, input logic e, input int tag);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        x.cyc   = cyc + 1 + LAT;
        x.tag   = tag;
        sb.push_back(x);
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee, input int tag);
        wait_idle();
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        expect_resp(er, ee, tag);
        @(negedge clk);
        bus.req = 1'b0;
        wait_drain();
    endtask

    // Scoreboard side: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ready === 1'b1) begin
            ready_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ready: ready=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("rdata#%0d", mon_e.tag), bus.rdata, mon_e.rdata);
                check($sformatf("err#%0d", mon_e.tag), 32'(bus.err), 32'(mon_e.err));
                check($sformatf("latency#%0d", mon_e.tag), 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    addr          wdata         exp_rdata     exp_err
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0400, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0001, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0000_0001, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_07FC, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[8] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};

        h_addr[0] = 32'h10; h_exp[0] = 32'hDEAD_BEEF;
        h_addr[1] = 32'h20; h_exp[1] = 32'hCAFE_F00D;
        h_addr[2] = 32'h40; h_exp[2] = 32'hAAAA_0000;

        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_err",   32'(bus.err),   32'h0);
        check("rst_rdata", bus.rdata,      32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single accesses: write/read, wrap-around, held rdata across writes
        for (int i = 0; i < 9; i++)
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, i);

        // Reset in the middle of WAIT aborts the write
        access(1'b1, 32'h40, 32'hAAAA_0000, 32'hDEAD_BEEF, 1'b0, 20);
        wait_idle();
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'h5555_5555;
        @(negedge clk);
        bus.req = 1'b0;
        check("abort_busy_before", 32'(bus.busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("abort_ready", 32'(bus.ready), 32'h0);
        check("abort_busy",  32'(bus.busy),  32'h0);
        check("abort_rdata", bus.rdata,      32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(1'b0, 32'h40, 32'h0, 32'hAAAA_0000, 1'b0, 21);

        // req held high across three reads; addr changes while busy must be ignored
        ready_cycs.delete();
        for (int k = 0; k < 3; k++) begin
            wait_idle();
            if (k == 0) begin
                bus.req = 1'b1; bus.we = 1'b0; bus.addr = h_addr[0]; bus.wdata = 32'h0BAD_0BAD;
            end
            expect_resp(h_exp[k], 1'b0, 30 + k);
            @(negedge clk);
            check($sformatf("held_busy#%0d", k), 32'(bus.busy), 32'h1);
            if (k < 2) bus.addr = h_addr[k+1];
            else bus.req = 1'b0;
        end
        wait_drain();
        if (ready_cycs.size() == 3) begin
            check("held_spacing0", 32'(ready_cycs[1] - ready_cycs[0]), 32'd4);
            check("held_spacing1", 32'(ready_cycs[2] - ready_cycs[1]), 32'd4);
        end else begin
            check("held_ready_count", 32'(ready_cycs.size()), 32'd3);
        end

        // Misaligned write
`ifdef MEM_RESP_ALIGN_CHECK_EN
        access(1'b1, 32'h13, 32'hFF, 32'h0, 1'b1, 40);
        access(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 41);
        final_rdata = 32'hDEAD_BEEF;
`else
        access(1'b1, 32'h13, 32'hFF, 32'hAAAA_0000, 1'b0, 40);
        access(1'b0, 32'h10, 32'h0, 32'h0000_00FF, 1'b0, 41);
        final_rdata = 32'h0000_00FF;
`endif

        // Quiet bus: outputs idle, read data held
        repeat (5) @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'h0);
        check("idle_busy",  32'(bus.busy),  32'h0);
        check("idle_err",   32'(bus.err),   32'h0);
        check("held_rdata", bus.rdata,      final_rdata);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
